systolic_feeder: RTL and testbench
==================================

Name: systolic_feeder

Overview:
Upstream feeder for the 9x9 systolic PE array. Holds operand matrices A (rows, west edge) and B (columns, north edge), 4-bit elements, loaded one element per cycle. On start, it drives the diagonally skewed operand wavefront that the array edges need. It then drains zeros and pulses done when every PE holds its final accumulated product.

Parameters:
N, 9, array dimension (rows of A = cols of B = inner dimension)
DW, 4, element width
CW, 5, width of the step counter (must hold 2N-1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted at 0)
wr_en  in  1  element write strobe
wr_sel  in  1  0 = matrix A, 1 = matrix B
wr_row  in  4  row index
wr_col  in  4  column index
wr_data  in  DW  element value
start  in  1  begin a streaming run
west_data  out  N*DW  slice i [i*DW +: DW] drives array row i west input
north_data  out  N*DW  slice j drives array column j north input
acc_clr  out  1  one-cycle clear pulse for array accumulators, active-high
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at end of run

Behaviour:
- Reset (rst=0, async): state=IDLE, step=0, all A/B storage cleared to 0, west_data=0, north_data=0, acc_clr=0, busy=0, done=0.
- All outputs are registered. Values below are what is visible during the named cycle.
- Writes: accepted only in IDLE on a rising edge with wr_en=1. wr_row>=N or wr_col>=N: write dropped, storage unchanged. A write in any other state is ignored.
- States:
  - IDLE: start=1 -> CLEAR.
  - CLEAR: 1 cycle. acc_clr=1, data outputs 0. -> STREAM with step=0.
  - STREAM: steps 0..2N-2 (17 cycles).
    - west slice i = A[i][step-i] if 0<=step-i<N, else 0.
    - north slice j = B[step-j][j] if 0<=step-j<N, else 0.
    - After step 2N-2 -> DRAIN, step=0.
  - DRAIN: N cycles (9). Data outputs 0, letting the last operands traverse the array. At the last DRAIN cycle -> DONE.
  - DONE: 1 cycle. done=1, busy=1. -> IDLE.
- Latency: the start edge is followed by CLEAR(1) + STREAM(17) + DRAIN(9) + DONE(1). done is high in the 28th cycle after the start edge.
- Write and start on the same IDLE edge: the write commits, and the run uses the updated value.
- start while busy=1: ignored, no restart, no queueing.
- Storage is not modified by a run; back-to-back runs with no writes in between produce identical streams.
- Reset mid-run: immediate return to IDLE, outputs 0, storage cleared. No done pulse for the aborted run.
- Step counter saturates within state; no wrap-around beyond 2N-2.

Test Plan:
- Reset: hold rst=0 with wr_en/start toggling -> all outputs 0, busy=0. After release, a start with no writes streams all zeros and done fires 28 cycles after the start edge.
- Single element: write A[0][0]=5, B[0][0]=3, start -> acc_clr=1 in cycle 1. STREAM step 0 shows west slice0=5 and north slice0=3; every other slice and step is 0.
- Skew: write A[i][k]=k+1 and B[k][j]=j+1 for all i,k,j, then start -> at step 4, west slice2=3 (A[2][2]), west slice5=0, north slice4=5 (B[0][4]). At step 16 only west slice8=9 and north slice8=9 are nonzero.
- Illegal write and write while busy: write A[9][0]=7 in IDLE -> dropped. Write A[0][0]=7 during STREAM -> ignored. The next run still shows west slice0=previous value at step 0.
- start while busy: pulse start at STREAM step 3 -> no state change, exactly one done pulse, 28 cycles after the original start edge.
- Reset mid-run: rst=0 at STREAM step 8 -> outputs 0 and busy=0 immediately, no done pulse. A subsequent start streams all zeros because storage was cleared.

Source files
------------

// File: rtl/systolic_feeder.sv
// systolic_feeder: holds A/B operand matrices and streams the skewed wavefront into a NxN systolic array.
module systolic_feeder #(
    parameter int N  = 9,
    parameter int DW = 4,
    parameter int CW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic            wr_sel,
    input  logic [3:0]      wr_row,
    input  logic [3:0]      wr_col,
    input  logic [DW-1:0]   wr_data,
    input  logic            start,
    output logic [N*DW-1:0] west_data,
    output logic [N*DW-1:0] north_data,
    output logic            acc_clr,
    output logic            busy,
    output logic            done
);
    localparam int AW = $clog2(N);
    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;
    state_t state;
    logic [CW-1:0] step, nstep;
    logic [DW-1:0] a_mem [N][N];
    logic [DW-1:0] b_mem [N][N];
    logic [N*DW-1:0] west_nxt, north_nxt;
    logic wr_ok;
    // Outputs are registered, so the wavefront is computed for the step about to be shown
    assign nstep = (state == STREAM) ? step + 1'b1 : '0;
    assign wr_ok = wr_en && wr_row < 4'(N) && wr_col < 4'(N);
    for (genvar i = 0; i < N; i++) begin : g_wave
        logic [CW-1:0] k;
        logic          hit;
        assign k   = nstep - CW'(i);
        assign hit = nstep >= CW'(i) && k < CW'(N);
        assign west_nxt[i*DW +: DW]  = hit ? a_mem[i][k[AW-1:0]] : '0;
        assign north_nxt[i*DW +: DW] = hit ? b_mem[k[AW-1:0]][i] : '0;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            step       <= '0;
            west_data  <= '0;
            north_data <= '0;
            acc_clr    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                    a_mem[r][c] <= '0;
                    b_mem[r][c] <= '0;
                end
        end else begin
            acc_clr <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_ok && !wr_sel) a_mem[wr_row][wr_col] <= wr_data;
                    if (wr_ok && wr_sel) b_mem[wr_row][wr_col] <= wr_data;
                    if (start) begin
                        state   <= CLEAR;
                        step    <= '0;
                        acc_clr <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                CLEAR: begin
                    state      <= STREAM;
                    step       <= '0;
                    west_data  <= west_nxt;
                    north_data <= north_nxt;
                end
                STREAM: begin
                    if (step == CW'(2*N-2)) begin
                        state      <= DRAIN;
                        step       <= '0;
                        west_data  <= '0;
                        north_data <= '0;
                    end else begin
                        step       <= step + 1'b1;
                        west_data  <= west_nxt;
                        north_data <= north_nxt;
                    end
                end
                DRAIN: begin
                    if (step == CW'(N-1)) begin
                        state <= DONE;
                        step  <= '0;
                        done  <= 1'b1;
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: table vectors, corner sequences and random runs against a matrix-level model.
module tb_systolic_feeder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0;
    logic [3:0]  wr_row = '0, wr_col = '0, wr_data = '0;
    logic [35:0] west_data, north_data;
    logic        acc_clr, busy, done;

    systolic_feeder dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row),
        .wr_col(wr_col), .wr_data(wr_data), .start(start), .west_data(west_data),
        .north_data(north_data), .acc_clr(acc_clr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       sel;
        logic [3:0] row, col, data;
        int         step;
        logic       nth;
        int         slice;
        logic [3:0] exp;
    } vec_t;
    vec_t tbl[10];

    int ma[9][9], mb[9][9];
    logic [35:0] obs_w[17], obs_n[17];
    int nvec = 0, nerr = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [74:0] got, input logic [74:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 9; i++)
            for (int k = 0; k < 9; k++) begin
                ma[i][k] = 0;
                mb[i][k] = 0;
            end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        clear_model();
    endtask

    task automatic put(input logic sel, input int row, input int col, input logic [3:0] data, input logic st);
        wr_en = 1'b1; wr_sel = sel; wr_row = row[3:0]; wr_col = col[3:0]; wr_data = data; start = st;
        tick();
        wr_en = 1'b0; start = 1'b0;
        if (row < 9 && col < 9) begin
            if (sel) mb[row][col] = int'(data);
            else ma[row][col] = int'(data);
        end
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called in cycle 1 after the start edge; checks cycles 1..29 against the matrix model
    task automatic run_check(input bit inject);
        logic [35:0] ew, en;
        int k;
        for (int c = 1; c <= 29; c++) begin
            ew = '0;
            en = '0;
            if (c >= 2 && c <= 18)
                for (int i = 0; i < 9; i++) begin
                    k = c - 2 - i;
                    if (k >= 0 && k < 9) begin
                        ew[i*4 +: 4] = 4'(ma[i][k]);
                        en[i*4 +: 4] = 4'(mb[k][i]);
                    end
                end
            chk($sformatf("run cycle %0d", c), {west_data, north_data, acc_clr, busy, done},
                {ew, en, c == 1, c <= 28, c == 28});
            if (c >= 2 && c <= 18) begin
                obs_w[c-2] = west_data;
                obs_n[c-2] = north_data;
            end
            wr_en = 1'b0;
            start = 1'b0;
            if (inject && c == 5) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_row = 4'd0; wr_col = 4'd0; wr_data = 4'd7; start = 1'b1;
            end
            tick();
        end
        wr_en = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] got;
        logic seen;
        tbl[0] = '{1'b0, 4'd0, 4'd0, 4'd5, 0,  1'b0, 0, 4'd5};
        tbl[1] = '{1'b1, 4'd0, 4'd0, 4'd3, 0,  1'b1, 0, 4'd3};
        tbl[2] = '{1'b0, 4'd2, 4'd2, 4'd3, 4,  1'b0, 2, 4'd3};
        tbl[3] = '{1'b1, 4'd0, 4'd4, 4'd5, 4,  1'b1, 4, 4'd5};
        tbl[4] = '{1'b0, 4'd9, 4'd0, 4'd7, 0,  1'b0, 0, 4'd0};
        tbl[5] = '{1'b1, 4'd8, 4'd8, 4'd9, 16, 1'b1, 8, 4'd9};
        tbl[6] = '{1'b0, 4'd8, 4'd8, 4'd9, 16, 1'b0, 8, 4'd9};
        tbl[7] = '{1'b0, 4'd3, 4'd5, 4'd6, 8,  1'b0, 3, 4'd6};
        tbl[8] = '{1'b1, 4'd5, 4'd2, 4'd4, 7,  1'b1, 2, 4'd4};
        tbl[9] = '{1'b0, 4'd4, 4'd1, 4'd2, 5,  1'b0, 4, 4'd2};

        // Reset held with inputs toggling
        clear_model();
        for (int c = 0; c < 4; c++) begin
            wr_en = c[0]; start = ~c[0]; wr_data = 4'd9;
            tick();
            chk("reset hold", {west_data, north_data, acc_clr, busy, done}, '0);
        end
        wr_en = 1'b0; start = 1'b0;
        rst = 1'b1;
        tick();
        go();
        run_check(1'b0);

        // Table: single write on the same edge as start, then one slice probed
        for (int n = 0; n < 10; n++) begin
            do_reset();
            put(tbl[n].sel, int'(tbl[n].row), int'(tbl[n].col), tbl[n].data, 1'b1);
            run_check(1'b0);
            got = tbl[n].nth ? obs_n[tbl[n].step][tbl[n].slice*4 +: 4] : obs_w[tbl[n].step][tbl[n].slice*4 +: 4];
            chk($sformatf("vec%0d", n), 75'(got), 75'(tbl[n].exp));
        end

        // Full skew pattern, with a write and a start injected at STREAM step 3
        do_reset();
        for (int i = 0; i < 9; i++)
            for (int k = 0; k < 9; k++) begin
                put(1'b0, i, k, 4'(k + 1), 1'b0);
                put(1'b1, i, k, 4'(k + 1), 1'b0);
            end
        go();
        run_check(1'b1);
        chk("skew w2 s4", 75'(obs_w[4][8 +: 4]), 75'(3));
        chk("skew w5 s4", 75'(obs_w[4][20 +: 4]), 75'(0));
        chk("skew n4 s4", 75'(obs_n[4][16 +: 4]), 75'(5));
        chk("skew s16", 75'({obs_w[16], obs_n[16]}), {3'b0, 4'd9, 32'd0, 4'd9, 32'd0});
        go();
        run_check(1'b0);
        chk("busy write", 75'(obs_w[0][3:0]), 75'(1));

        // Reset at STREAM step 8 clears everything with no done
        go();
        for (int c = 1; c < 10; c++) tick();
        chk("busy before abort", 75'(busy), 75'(1));
        #2 rst = 1'b0;
        #1 chk("mid reset", {west_data, north_data, acc_clr, busy, done}, '0);
        tick();
        rst = 1'b1;
        clear_model();
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            seen |= done | busy;
        end
        chk("no done after abort", 75'(seen), 75'(0));
        go();
        run_check(1'b0);

        // Random writes including out-of-range indices; last write shares the start edge
        for (int r = 0; r < 4; r++) begin
            for (int n = 0; n < 15; n++)
                put(1'($urandom_range(0, 1)), int'($urandom_range(0, 10)), int'($urandom_range(0, 10)),
                    4'($urandom_range(0, 15)), n == 14);
            run_check(1'b0);
        end
        go();
        run_check(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
